// File: rtl/fifo_rd_packer_if.sv
// Bundle for the packer: FIFO read side (rdata/rempty/rinc/flush) and the packed beat stream.
// The packer sits on the master modport. The FIFO and downstream environment sit on slave.
interface fifo_rd_packer_if #(
  parameter int DSIZE = 8,
  parameter int PACK  = 4
);
  logic [DSIZE-1:0]      rdata;
  logic                  rempty;
  logic                  rinc;
  logic                  flush;
  logic [DSIZE*PACK-1:0] m_data;
  logic [PACK-1:0]       m_keep;
  logic                  m_valid;
  logic                  m_ready;
  logic [15:0]           beat_cnt;

  modport master (
    input  rdata, rempty, flush, m_ready,
    output rinc, m_data, m_keep, m_valid, beat_cnt
  );

  modport slave (
    output rdata, rempty, flush, m_ready,
    input  rinc, m_data, m_keep, m_valid, beat_cnt
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops words from a FIFO head and packs PACK of them into one wide beat.
// Partial beats are released by flush or after TIMEOUT consecutive empty cycles.
module fifo_rd_packer #(
  parameter int DSIZE   = 8,
  parameter int PACK    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              rclk,
  input  logic              rrst,
  fifo_rd_packer_if.master  bus
);
  localparam int CW = $clog2(PACK);
  localparam int IW = $clog2(TIMEOUT);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [DSIZE*PACK-1:0] data_q;
  logic [PACK-1:0]       keep_q;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idle;
  logic [15:0]           beat_cnt_q;
  logic                  rinc, m_valid;
  logic                  last_lane, timeout_hit;

  assign last_lane   = (cnt == CW'(PACK - 1));
  assign timeout_hit = (idle == IW'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge rclk) begin
    if (rrst) state <= COLLECT;
    else      state <= state_nxt;
  end

  // NOTE: each always_comb output gets a default first. This keeps every path assigned and infers no latch.
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: begin
        if (rinc) begin
          if (last_lane || bus.flush) state_nxt = HOLD;
        end else if (cnt != '0 && bus.rempty && (bus.flush || timeout_hit)) begin
          state_nxt = HOLD;
        end
      end
      HOLD:    if (bus.m_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // Popping in HOLD is only safe when the held beat leaves on this same edge.
  always_comb begin
    rinc    = 1'b0;
    m_valid = 1'b0;
    case (state)
      COLLECT: rinc = ~bus.rempty;
      HOLD: begin
        m_valid = 1'b1;
        rinc    = bus.m_ready & ~bus.rempty;
      end
      default: ;
    endcase
    if (rrst) rinc = 1'b0;
  end

  // NOTE: the beat buffer is reset on purpose. Unwritten lanes must read as zero, including after a reset.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      data_q     <= '0;
      keep_q     <= '0;
      cnt        <= '0;
      idle       <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (rinc) begin
            data_q[int'(cnt)*DSIZE +: DSIZE] <= bus.rdata;
            keep_q[cnt] <= 1'b1;
            idle        <= '0;
            cnt         <= (state_nxt == HOLD) ? '0 : cnt + CW'(1);
          end else if (cnt != '0 && bus.rempty) begin
            if (state_nxt == HOLD) begin
              cnt  <= '0;
              idle <= '0;
            end else begin
              idle <= idle + IW'(1);
            end
          end
        end
        HOLD: begin
          if (bus.m_ready) begin
            beat_cnt_q <= beat_cnt_q + 16'd1;
            data_q     <= '0;
            keep_q     <= '0;
            cnt        <= '0;
            idle       <= '0;
            if (rinc) begin
              data_q[DSIZE-1:0] <= bus.rdata;
              keep_q[0]         <= 1'b1;
              cnt               <= CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rinc     = rinc;
  assign bus.m_valid  = m_valid;
  assign bus.m_data   = data_q;
  assign bus.m_keep   = keep_q;
  assign bus.beat_cnt = beat_cnt_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer. Stimulus queues expected beats and a negedge monitor
// compares every transfer against the queue.
module tb_fifo_rd_packer;
  localparam int DSIZE   = 8;
  localparam int PACK    = 4;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
  } beat_t;

  logic rclk = 1'b0;
  logic rrst;
  always #5 rclk = ~rclk;

  fifo_rd_packer_if #(.DSIZE(DSIZE), .PACK(PACK)) bus ();

  fifo_rd_packer #(.DSIZE(DSIZE), .PACK(PACK), .TIMEOUT(TIMEOUT)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus.master)
  );

  beat_t sb[$];
  int    total     = 0;
  int    bad       = 0;
  int    exp_beats = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic [3:0] k);
    beat_t b;
    b.data = d;
    b.keep = k;
    sb.push_back(b);
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic pop_word(input logic [7:0] w, input logic fl);
    bus.rempty = 1'b0;
    bus.rdata  = w;
    bus.flush  = fl;
    @(negedge rclk);
    check("rinc_on_pop", 32'(bus.rinc), 1);
    tick();
    bus.rempty = 1'b1;
    bus.flush  = 1'b0;
  endtask

  task automatic empty_cycle();
    bus.rempty = 1'b1;
    tick();
  endtask

  // Transfers happen at the next posedge whenever valid&ready is seen here.
  always @(negedge rclk) begin
    beat_t e;
    if (rrst) begin
      exp_beats = 0;
    end else if (bus.m_valid && bus.m_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 32'(bus.m_valid), 0);
      end else begin
        e = sb.pop_front();
        check("beat_data", bus.m_data, e.data);
        check("beat_keep", 32'(bus.m_keep), 32'(e.keep));
        check("beat_cnt", 32'(bus.beat_cnt), exp_beats);
        exp_beats++;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rrst        = 1'b1;
    bus.rdata   = 8'h99;
    bus.rempty  = 1'b0;
    bus.flush   = 1'b0;
    bus.m_ready = 1'b1;
    @(negedge rclk);
    check("rinc_in_reset", 32'(bus.rinc), 0);
    tick();
    tick();
    check("rst_valid", 32'(bus.m_valid), 0);
    check("rst_data", bus.m_data, 0);
    check("rst_keep", 32'(bus.m_keep), 0);
    check("rst_beat_cnt", 32'(bus.beat_cnt), 0);
    rrst       = 1'b0;
    bus.rempty = 1'b1;
    bus.rdata  = 8'h00;

    // Full beat, back-to-back pops
    expect_beat(32'h44332211, 4'hF);
    pop_word(8'h11, 1'b0);
    pop_word(8'h22, 1'b0);
    pop_word(8'h33, 1'b0);
    pop_word(8'h44, 1'b0);
    check("full_latency", 32'(bus.m_valid), 1);
    empty_cycle();
    check("after_xfer_valid", 32'(bus.m_valid), 0);
    check("after_xfer_data", bus.m_data, 0);
    check("after_xfer_keep", 32'(bus.m_keep), 0);
    check("after_xfer_cnt", 32'(bus.beat_cnt), 1);

    // Partial beat released by timeout
    expect_beat(32'h0000BBAA, 4'h3);
    pop_word(8'hAA, 1'b0);
    pop_word(8'hBB, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      empty_cycle();
      check("timeout_early", 32'(bus.m_valid), 0);
    end
    empty_cycle();
    check("timeout_fire", 32'(bus.m_valid), 1);
    empty_cycle();
    check("timeout_drained", 32'(bus.m_valid), 0);

    // Back-pressure in HOLD, then pop in the transfer cycle
    bus.m_ready = 1'b0;
    expect_beat(32'h0D0C0B0A, 4'hF);
    pop_word(8'h0A, 1'b0);
    pop_word(8'h0B, 1'b0);
    pop_word(8'h0C, 1'b0);
    pop_word(8'h0D, 1'b0);
    check("hold_valid", 32'(bus.m_valid), 1);
    bus.rempty = 1'b0;
    bus.rdata  = 8'hE1;
    for (int i = 0; i < 5; i++) begin
      @(negedge rclk);
      check("hold_rinc", 32'(bus.rinc), 0);
      check("hold_data", bus.m_data, 32'h0D0C0B0A);
      check("hold_keep", 32'(bus.m_keep), 32'hF);
      tick();
    end
    bus.m_ready = 1'b1;
    @(negedge rclk);
    check("hold_pop_rinc", 32'(bus.rinc), 1);
    tick();
    bus.rempty = 1'b1;
    check("nobubble_valid", 32'(bus.m_valid), 0);
    check("nobubble_keep", 32'(bus.m_keep), 32'h1);
    check("nobubble_data", bus.m_data, 32'h000000E1);
    expect_beat(32'h000000E1, 4'h1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_e1_valid", 32'(bus.m_valid), 1);
    empty_cycle();

    // Flush with nothing collected does nothing
    bus.flush = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("flush_empty", 32'(bus.m_valid), 0);
    end
    bus.flush = 1'b0;
    expect_beat(32'h0000005C, 4'h1);
    pop_word(8'h5C, 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_valid", 32'(bus.m_valid), 1);
    empty_cycle();

    // Flush together with a pop includes the popped word
    expect_beat(32'h00007170, 4'h3);
    pop_word(8'h70, 1'b0);
    pop_word(8'h71, 1'b1);
    check("flush_pop_valid", 32'(bus.m_valid), 1);
    empty_cycle();

    // Reset mid-collect discards the partial beat
    pop_word(8'h01, 1'b0);
    pop_word(8'h02, 1'b0);
    pop_word(8'h03, 1'b0);
    rrst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(bus.m_valid), 0);
    check("mid_rst_data", bus.m_data, 0);
    check("mid_rst_keep", 32'(bus.m_keep), 0);
    check("mid_rst_beat_cnt", 32'(bus.beat_cnt), 0);
    rrst = 1'b0;
    expect_beat(32'h84838281, 4'hF);
    pop_word(8'h81, 1'b0);
    pop_word(8'h82, 1'b0);
    pop_word(8'h83, 1'b0);
    pop_word(8'h84, 1'b0);
    check("post_rst_valid", 32'(bus.m_valid), 1);
    empty_cycle();
    check("post_rst_beat_cnt", 32'(bus.beat_cnt), 1);

    tick();
    check("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 Parameter: DSIZE, default 8, width of one FIFO read word.
REQ-002 Parameter: PACK, default 4, number of FIFO words packed per output beat (>=2).
REQ-003 Parameter: TIMEOUT, default 16, consecutive empty cycles before a partial beat is emitted (>=2).
REQ-004 Port: rclk  input  1  single clock; all logic rising-edge on rclk.
REQ-005 Port: rrst  input  1  reset, synchronous, active-high.
REQ-006 Port: rdata  input  DSIZE  FIFO head word, valid combinationally whenever rempty=0.
REQ-007 Port: rempty  input  1  FIFO empty flag.
REQ-008 Port: rinc  output  1  FIFO pop; head word consumed at the rclk edge where rinc=1.
REQ-009 Port: flush  input  1  request to emit any partially collected beat.
REQ-010 Port: m_data  output  DSIZE*PACK  packed beat; lane i = bits [DSIZE*i +: DSIZE].
REQ-011 Port: m_keep  output  PACK  lane-valid mask for m_data.
REQ-012 Port: m_valid  output  1  beat valid.
REQ-013 Port: m_ready  input  1  downstream accept; beat transfers on an edge with m_valid=1 and m_ready=1.
REQ-014 Port: beat_cnt  output  16  count of transferred beats, wraps 0xFFFF->0x0000.

Function
REQ-015 The block SHALL have two states: COLLECT (m_valid=0) and HOLD (m_valid=1).
REQ-016 The block SHALL use a lane counter cnt (0..PACK-1) and an idle counter idle (0..TIMEOUT-1).
REQ-017 In COLLECT: rinc = ~rempty; on a pop, rdata is written to lane cnt, m_keep[cnt] is set, cnt increments, and idle clears.
REQ-018 In COLLECT, a pop into lane PACK-1 SHALL move to HOLD next cycle with m_keep all ones and cnt=0.
REQ-019 In COLLECT with cnt>0 and rempty=1: idle increments each cycle; when idle=TIMEOUT-1, the next state SHALL be HOLD with the partial m_keep (i.e. TIMEOUT empty cycles after the last pop).
REQ-020 In COLLECT with cnt>0, flush=1 and rempty=1 SHALL move to HOLD next cycle with the partial beat; flush=1 with rempty=0 SHALL pop first and then emit, including that word.
REQ-021 flush or timeout with cnt=0 SHALL have no effect; idle SHALL stay 0 while cnt=0.
REQ-022 Lanes not yet written SHALL read as zero in m_data; data lands in lane 0 first.
REQ-023 In HOLD: m_data and m_keep SHALL be stable while m_ready=0, and rinc = m_ready & ~rempty.
REQ-024 HOLD with m_ready=1 and rempty=1 SHALL return to COLLECT with m_data=0, m_keep=0, cnt=0, idle=0.
REQ-025 HOLD with m_ready=1 and rempty=0 SHALL pop in the same cycle, return to COLLECT with lane 0 = popped word, m_keep=1, cnt=1, and the other lanes zero (no bubble).
REQ-026 beat_cnt SHALL increment on every transfer edge.
REQ-027 Latency: m_valid SHALL rise on the edge after the pop that completes a full beat.
REQ-028 rinc SHALL never be 1 while rempty=1 or rrst=1.

Reset
REQ-029 While rrst=1 at an edge: state=COLLECT, m_valid=0, m_data=0, m_keep=0, cnt=0, idle=0, beat_cnt=0; rinc is held 0 combinationally while rrst=1.
REQ-030 Reset asserted mid-collect or in HOLD SHALL discard the partial or held beat with no transfer and no beat_cnt change.

Verification
REQ-031 Pop 0x11,0x22,0x33,0x44 on back-to-back cycles with m_ready=1 -> m_valid=1 on the next edge, m_data=0x44332211, m_keep=4'b1111, beat_cnt=1.
REQ-032 Pop 0xAA,0xBB, then hold rempty=1 for 16 cycles -> m_valid rises after the 16th empty cycle, m_data=0x0000BBAA, m_keep=4'b0011.
REQ-033 Full beat in HOLD, m_ready=0 for 5 cycles with rempty=0 -> rinc=0 throughout and m_data unchanged; m_ready=1 then pops the next word into lane 0, m_keep=4'b0001.
REQ-034 flush=1 with cnt=0 for 20 cycles -> m_valid stays 0; one pop 0x5C, then flush with rempty=1 -> m_data=0x0000005C, m_keep=4'b0001.
REQ-035 Three words popped, then rrst=1 for one edge -> all outputs 0, beat_cnt=0; the next 4 pops produce a full beat containing only the post-reset words.
